core_pagefault_pipe: RTL and testbench

CORE_PAGEFAULT_PIPE -- requirements
Module: corevx_pagefault_pipe

---
 rtl/core_pagefault_pipe.sv | 171 +++++++++++++++++
 tb/tb_core_pagefault_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_pagefault_pipe.sv
// -----------------------------------------------------------------------------
// core_pagefault_pipe
//   Decides whether a translated memory access raises a page fault. The PTE
//   flags, the leaf level and the CSR state that matter for the decision are
//   sampled on the accept cycle. The verdict comes out of a single
//   valid/ready output register one cycle later.
//   The module also counts delivered faults in a saturating counter and keeps
//   the cause of the most recent delivered fault.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           request handshake
//   in_cmd                      0 NONE, 1 LOAD, 2 STORE, 3 EXECUTE
//   in_accesstag                PTE flags {D,A,G,U,X,W,R,V}
//   in_level                    leaf level (0 = 4 KiB page)
//   in_ppn_low                  low PPN segments of the leaf PTE
//   csr_* / os_csr_*            translation mode, mstatus bits, privilege
//   out_valid/out_ready         result handshake
//   out_pagefault, out_cause    verdict (cause 12 exec, 13 load, 15 store)
//   fault_count                 saturating count of delivered faults
//   fault_last_cause            cause of the most recent delivered fault
//   fault_clear                 synchronous clear of the two fields above
// -----------------------------------------------------------------------------
module core_pagefault_pipe #(
  parameter int LEVELS    = 2,
  parameter int PPN_SEG_W = 10,
  parameter int CNT_W     = 8,
  localparam int LVL_W    = $clog2(LEVELS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [3:0]                        in_cmd,
  input  logic [7:0]                        in_accesstag,
  input  logic [LVL_W-1:0]                  in_level,
  input  logic [(LEVELS-1)*PPN_SEG_W-1:0]   in_ppn_low,
  input  logic                              csr_satp_mode_r,
  input  logic                              os_csr_mstatus_mprv,
  input  logic                              os_csr_mstatus_mxr,
  input  logic                              os_csr_mstatus_sum,
  input  logic [1:0]                        os_csr_mstatus_mpp,
  input  logic [1:0]                        os_csr_mcurrent_privilege,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_pagefault,
  output logic [3:0]                        out_cause,
  output logic [CNT_W-1:0]                  fault_count,
  output logic [3:0]                        fault_last_cause,
  input  logic                              fault_clear
);

  localparam logic [3:0] CMD_NONE    = 4'd0;
  localparam logic [3:0] CMD_LOAD    = 4'd1;
  localparam logic [3:0] CMD_STORE   = 4'd2;
  localparam logic [3:0] CMD_EXECUTE = 4'd3;

  localparam logic [1:0] PRIV_USER       = 2'd0;
  localparam logic [1:0] PRIV_SUPERVISOR = 2'd1;
  localparam logic [1:0] PRIV_MACHINE    = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Counter increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic             out_valid_q, out_valid_d;
  logic             out_pf_q, out_pf_d;
  logic [3:0]       out_cause_q, out_cause_d;
  logic [CNT_W-1:0] fault_count_q, fault_count_d;
  logic [3:0]       fault_last_q, fault_last_d;

  logic       accept, deliver;
  logic [1:0] eff_priv;
  logic       bypass, perm_fault, priv_fault, misalign, req_fault;
  logic [3:0] req_cause;
  logic       pte_v, pte_r, pte_w, pte_x, pte_u, pte_a, pte_d;

  // The global bit does not influence the fault decision.
  logic unused_global;
  assign unused_global = in_accesstag[5];

  assign {pte_d, pte_a} = in_accesstag[7:6];
  assign {pte_u, pte_x, pte_w, pte_r, pte_v} = in_accesstag[4:0];

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid_q && out_ready && out_pf_q;

  always_comb begin
    // MPRV applies the previous privilege to data accesses only.
    eff_priv = (os_csr_mstatus_mprv && in_cmd != CMD_EXECUTE)
             ? os_csr_mstatus_mpp : os_csr_mcurrent_privilege;
    bypass = !csr_satp_mode_r || eff_priv == PRIV_MACHINE || in_cmd == CMD_NONE;

    perm_fault = !pte_v || (!pte_r && pte_w) || !pte_a
              || (in_cmd == CMD_STORE && (!pte_d || !pte_w))
              || (in_cmd == CMD_EXECUTE && !pte_x)
              || (in_cmd == CMD_LOAD && !pte_r && !(os_csr_mstatus_mxr && pte_x));

    priv_fault = (eff_priv == PRIV_USER && !pte_u)
              || (eff_priv == PRIV_SUPERVISOR && pte_u
                  && (!os_csr_mstatus_sum || in_cmd == CMD_EXECUTE));

    // A superpage leaf must have every PPN segment below its level zero.
    misalign = (int'(in_level) >= LEVELS);
    for (int k = 0; k < LEVELS - 1; k++) begin
      if (k < int'(in_level) && in_ppn_low[k*PPN_SEG_W +: PPN_SEG_W] != '0)
        misalign = 1'b1;
    end

    req_fault = !bypass && (perm_fault || priv_fault || misalign);
    req_cause = 4'd0;
    if (req_fault) begin
      if (in_cmd == CMD_EXECUTE)    req_cause = 4'd12;
      else if (in_cmd == CMD_STORE) req_cause = 4'd15;
      else                          req_cause = 4'd13;
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_pf_d      = out_pf_q;
    out_cause_d   = out_cause_q;
    fault_count_d = fault_count_q;
    fault_last_d  = fault_last_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_pf_d    = req_fault;
      out_cause_d = req_cause;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // A clear coinciding with a delivery keeps that delivery as the first count.
    if (fault_clear) begin
      fault_count_d = deliver ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
      fault_last_d  = deliver ? out_cause_q : 4'd0;
    end else if (deliver) begin
      fault_count_d = sat_inc(fault_count_q);
      fault_last_d  = out_cause_q;
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_pf_q      <= 1'b0;
      out_cause_q   <= 4'd0;
      fault_count_q <= '0;
      fault_last_q  <= 4'd0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_pf_q      <= out_pf_d;
      out_cause_q   <= out_cause_d;
      fault_count_q <= fault_count_d;
      fault_last_q  <= fault_last_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_pagefault    = out_pf_q;
  assign out_cause        = out_cause_q;
  assign fault_count      = fault_count_q;
  assign fault_last_cause = fault_last_q;

endmodule

// File: tb/tb_core_pagefault_pipe.sv
module tb_core_pagefault_pipe;

  localparam int LEVELS = 3;
  localparam int SEG    = 10;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int NONE = 0, LOAD = 1, STORE = 2, EXEC = 3;
  localparam int USER = 0, SUP = 1, MACH = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_cmd = '0;
  logic [7:0]        in_accesstag = '0;
  logic [1:0]        in_level = '0;
  logic [19:0]       in_ppn_low = '0;
  logic              satp = 1'b1, mprv = 1'b0, mxr = 1'b0, sum = 1'b0;
  logic [1:0]        mpp = '0, priv = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_pagefault;
  logic [3:0]        out_cause;
  logic [CNT_W-1:0]  fault_count;
  logic [3:0]        fault_last_cause;
  logic              fault_clear = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  core_pagefault_pipe #(.LEVELS(LEVELS), .PPN_SEG_W(SEG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_accesstag(in_accesstag),
    .in_level(in_level), .in_ppn_low(in_ppn_low),
    .csr_satp_mode_r(satp), .os_csr_mstatus_mprv(mprv),
    .os_csr_mstatus_mxr(mxr), .os_csr_mstatus_sum(sum),
    .os_csr_mstatus_mpp(mpp), .os_csr_mcurrent_privilege(priv),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pagefault(out_pagefault), .out_cause(out_cause),
    .fault_count(fault_count), .fault_last_cause(fault_last_cause),
    .fault_clear(fault_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference decision: returns {fault, cause[3:0]}.
  function automatic logic [4:0] model_result(
    input int cmd, input int tag, input int p, input int pp, input int mprv_v,
    input int mxr_v, input int sum_v, input int satp_v, input int level,
    input int ppn);
    int eff, cause;
    bit v, r, w, x, u, a, d, bad;
    eff = (mprv_v == 1 && cmd != EXEC) ? pp : p;
    if (satp_v == 0 || eff == MACH || cmd == NONE) return 5'd0;
    v = tag[0]; r = tag[1]; w = tag[2]; x = tag[3];
    u = tag[4]; a = tag[6]; d = tag[7];
    bad = !v || (!r && w) || !a
       || (cmd == STORE && !d) || (cmd == EXEC && !x) || (cmd == STORE && !w)
       || (cmd == LOAD && !r && !(mxr_v == 1 && x));
    if (eff == USER && !u) bad = 1;
    if (eff == SUP && u && (sum_v == 0 || cmd == EXEC)) bad = 1;
    // Superpage: all PPN bits below level*SEG must be zero.
    if (level >= LEVELS) bad = 1;
    else if ((ppn % (1 << (level * SEG))) != 0) bad = 1;
    cause = (cmd == EXEC) ? 12 : (cmd == STORE) ? 15 : 13;
    return bad ? {1'b1, 4'(cause)} : 5'd0;
  endfunction

  // Behavioural model of the handshake, output slot and fault statistics.
  int m_valid = 0, m_fault = 0, m_cause = 0, m_cnt = 0, m_last = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_fault = 0; m_cause = 0; m_cnt = 0; m_last = 0;
    end else begin
      bit del, acc;
      logic [4:0] res;
      del = (m_valid == 1) && out_ready && (m_fault == 1);
      if (fault_clear) begin
        m_cnt  = del ? 1 : 0;
        m_last = del ? m_cause : 0;
      end else if (del) begin
        m_cnt  = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        m_last = m_cause;
      end
      acc = in_valid && ((m_valid == 0) || out_ready);
      if (acc) begin
        res = model_result(in_cmd, in_accesstag, priv, mpp, mprv, mxr, sum,
                           satp, in_level, in_ppn_low);
        m_valid = 1; m_fault = res[4]; m_cause = res[3:0];
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready", in_ready, (m_valid == 0 || out_ready) ? 1 : 0);
    chk("out_valid", out_valid, m_valid);
    if (m_valid == 1) begin
      chk("out_pagefault", out_pagefault, m_fault);
      chk("out_cause", out_cause, m_cause);
    end
    chk("fault_count", fault_count, m_cnt);
    chk("fault_last_cause", fault_last_cause, m_last);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int cmd, input int tag, input int p, input int mxr_v,
                         input int sum_v, input int lvl, input int ppn);
    in_cmd = 4'(cmd); in_accesstag = 8'(tag); priv = 2'(p);
    mxr = 1'(mxr_v); sum = 1'(sum_v); in_level = 2'(lvl); in_ppn_low = 20'(ppn);
    satp = 1'b1; mprv = 1'b0; mpp = 2'd0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_pf", out_pagefault, 0);
    chk("rst_cause", out_cause, 0);
    chk("rst_count", fault_count, 0);
    chk("rst_last", fault_last_cause, 0);
    rst_n = 1'b1;

    // Pin the model to hand-computed results
    chk("model_load_nomxr", model_result(LOAD, 8'hD9, USER, 0, 0, 0, 0, 1, 0, 0), 5'h1D);
    chk("model_load_mxr",   model_result(LOAD, 8'hD9, USER, 0, 0, 1, 0, 1, 0, 0), 5'h00);
    chk("model_sup_exec",   model_result(EXEC, 8'hDF, SUP, 0, 0, 0, 1, 1, 0, 0), 5'h1C);
    chk("model_store_d0",   model_result(STORE, 8'h5F, USER, 0, 0, 0, 0, 1, 0, 0), 5'h1F);
    chk("model_misalign",   model_result(LOAD, 8'hDF, USER, 0, 0, 0, 0, 1, 1, 1), 5'h1D);
    chk("model_machine",    model_result(LOAD, 8'h00, MACH, 0, 0, 0, 0, 1, 0, 0), 5'h00);

    // Directed decisions, back to back with out_ready = 1
    out_ready = 1'b1;
    set_req(LOAD, 8'hD9, USER, 0, 0, 0, 0); in_valid = 1'b1; cyc();
    chk("d_load_valid", out_valid, 1);
    chk("d_load_pf", out_pagefault, 1);
    chk("d_load_cause", out_cause, 13);
    set_req(LOAD, 8'hD9, USER, 1, 0, 0, 0); cyc();
    chk("d_mxr_pf", out_pagefault, 0);
    chk("d_mxr_cause", out_cause, 0);
    set_req(EXEC, 8'hDF, SUP, 0, 1, 0, 0); cyc();
    chk("d_supexec_pf", out_pagefault, 1);
    chk("d_supexec_cause", out_cause, 12);
    set_req(STORE, 8'h5F, USER, 0, 0, 0, 0); cyc();
    chk("d_store_pf", out_pagefault, 1);
    chk("d_store_cause", out_cause, 15);
    set_req(LOAD, 8'hDF, USER, 0, 0, 1, 1); cyc();
    chk("d_seg0_pf", out_pagefault, 1);
    chk("d_seg0_cause", out_cause, 13);
    set_req(LOAD, 8'hDF, USER, 0, 0, 1, 20'h400); cyc();
    chk("d_seg1only_pf", out_pagefault, 0);
    set_req(LOAD, 8'hDF, USER, 0, 0, 3, 0); cyc();
    chk("d_badlevel_pf", out_pagefault, 1);
    in_valid = 1'b0; cyc();
    chk("d_drain_valid", out_valid, 0);

    // Backpressure: held result, then release
    out_ready = 1'b0;
    set_req(LOAD, 8'hD9, USER, 0, 0, 0, 0); in_valid = 1'b1; cyc();
    chk("s_a_valid", out_valid, 1);
    set_req(LOAD, 8'hDF, USER, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("s_in_ready", in_ready, 0);
      chk("s_hold_valid", out_valid, 1);
      chk("s_hold_pf", out_pagefault, 1);
      chk("s_hold_cause", out_cause, 13);
    end
    out_ready = 1'b1; #1;
    chk("s_release_ready", in_ready, 1);
    cyc();
    chk("s_b_valid", out_valid, 1);
    chk("s_b_pf", out_pagefault, 0);
    in_valid = 1'b0; cyc();
    chk("s_empty", out_valid, 0);

    // Counter: clear, saturate, clear with delivery
    fault_clear = 1'b1; cyc(); fault_clear = 1'b0;
    chk("c_clear_cnt", fault_count, 0);
    chk("c_clear_last", fault_last_cause, 0);
    set_req(LOAD, 8'hD9, USER, 0, 0, 0, 0); in_valid = 1'b1;
    repeat (5) cyc();
    in_valid = 1'b0; cyc();
    chk("c_sat_cnt", fault_count, 3);
    chk("c_sat_last", fault_last_cause, 13);
    set_req(STORE, 8'h5F, USER, 0, 0, 0, 0); in_valid = 1'b1; cyc();
    in_valid = 1'b0; fault_clear = 1'b1; cyc(); fault_clear = 1'b0;
    chk("c_clrdel_cnt", fault_count, 1);
    chk("c_clrdel_last", fault_last_cause, 15);

    // Reset during a stall
    out_ready = 1'b0;
    set_req(LOAD, 8'hD9, USER, 0, 0, 0, 0); in_valid = 1'b1; cyc();
    in_valid = 1'b0; cyc();
    chk("r_stall_valid", out_valid, 1);
    rst_n = 1'b0; #1;
    chk("r_async_valid", out_valid, 0);
    chk("r_async_cnt", fault_count, 0);
    chk("r_async_last", fault_last_cause, 0);
    chk("r_async_ready", in_ready, 1);
    cyc(); rst_n = 1'b1; out_ready = 1'b1;

    // Randomized traffic checked by the model on every cycle
    for (int i = 0; i < 3000; i++) begin
      int t;
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 7);
      fault_clear = ($urandom_range(0, 19) == 0);
      in_cmd      = 4'($urandom_range(0, 3));
      t = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) t = t | 8'hC1;
      in_accesstag = 8'(t);
      in_level   = 2'($urandom_range(0, 3));
      in_ppn_low = ($urandom_range(0, 1) == 1) ? 20'($urandom) : 20'd0;
      satp = ($urandom_range(0, 9) != 0);
      mprv = 1'($urandom_range(0, 1));
      mxr  = 1'($urandom_range(0, 1));
      sum  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: priv = 2'(USER); 1: priv = 2'(SUP); default: priv = 2'(MACH);
      endcase
      case ($urandom_range(0, 2))
        0: mpp = 2'(USER); 1: mpp = 2'(SUP); default: mpp = 2'(MACH);
      endcase
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1; fault_clear = 1'b0;
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
